// File: rtl/wb_commit_unit_pkg.sv
// Shared encodings for the write-back/commit stage: write-back source selects,
// condition codes, and the PC register index.
package wb_commit_unit_pkg;

  // Write-back data source select (WB_Ct[4:3])
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;
  localparam logic [1:0] WB_SEL_ZP9 = 2'b11;

  // Commit condition (WB_Ct[1:0])
  localparam logic [1:0] COND_ALWAYS  = 2'b00;
  localparam logic [1:0] COND_Z       = 2'b01;
  localparam logic [1:0] COND_C       = 2'b10;
  localparam logic [1:0] COND_ALWAYS2 = 2'b11;

  // Register index that aliases the program counter
  localparam int unsigned R7_IDX = 7;

  // Resolve a commit condition against the architectural flags
  function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
    logic ok;
    unique case (cond)
      COND_ALWAYS:  ok = 1'b1;
      COND_Z:       ok = z;
      COND_C:       ok = c;
      COND_ALWAYS2: ok = 1'b1;
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wb_commit_unit_data_mux.sv
// 4:1 write-back data select.
module wb_data_mux
  import wb_commit_unit_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] mem_do,
  input  logic [DW-1:0] pc_plus,
  input  logic [DW-1:0] zp9,
  output logic [DW-1:0] data
);

  // Pick the write-back source
  always_comb begin
    data = alu_out;
    unique case (sel)
      WB_SEL_ALU: data = alu_out;
      WB_SEL_MEM: data = mem_do;
      WB_SEL_PC:  data = pc_plus;
      WB_SEL_ZP9: data = zp9;
      default:    data = alu_out;
    endcase
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: resolves the commit condition against the architectural
// flags, drives the register-file write port, updates C/Z, keeps a one-deep
// forwarding register, flags PC (R7) writes as a redirect, and counts retirements.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned RW    = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             valid,
  input  logic [4:0]       WB_Ct,
  input  logic [RW-1:0]    Rd,
  input  logic [3:0]       opcode,
  input  logic             LW,
  input  logic             LM,
  input  logic [DW-1:0]    ALUout,
  input  logic [DW-1:0]    Mem_DO,
  input  logic [DW-1:0]    PC_plus,
  input  logic [DW-1:0]    ZP9,
  input  logic             c_in,
  input  logic             z_in,
  input  logic             c_we,
  input  logic             z_we,
  output logic             rf_we,
  output logic [RW-1:0]    rf_wa,
  output logic [DW-1:0]    rf_wd,
  output logic             c_flag,
  output logic             z_flag,
  output logic             fwd_valid,
  output logic [RW-1:0]    fwd_rd,
  output logic [DW-1:0]    fwd_data,
  output logic             pc_redirect,
  output logic [DW-1:0]    pc_target,
  output logic [CNT_W-1:0] retired
);

  logic live;
  logic cond_ok;
  logic commit;
  logic c_d;
  logic z_d;
  logic is_r7;

  // Opcode is decoded upstream into the LW/LM markers; not needed here
  logic unused_opcode;
  assign unused_opcode = ^opcode;

  wb_data_mux #(
    .DW(DW)
  ) u_data_mux (
    .sel     (WB_Ct[4:3]),
    .alu_out (ALUout),
    .mem_do  (Mem_DO),
    .pc_plus (PC_plus),
    .zp9     (ZP9),
    .data    (rf_wd)
  );

  // Commit decision and same-cycle register-file write port
  always_comb begin
    live    = valid & enable;
    // Registered flags only: a dependent instruction sees the previous commit's result
    cond_ok = cond_pass(WB_Ct[1:0], c_flag, z_flag);
    commit  = live & cond_ok;
    rf_we   = commit & WB_Ct[2];
    rf_wa   = Rd;
    is_r7   = (Rd == RW'(R7_IDX));
  end

  // Next flag values; LW derives Z from the loaded word, LM never touches flags
  always_comb begin
    c_d = c_flag;
    z_d = z_flag;
    if (commit && !LM) begin
      if (c_we) c_d = c_in;
      if (LW) begin
        z_d = (Mem_DO == '0);
      end else if (z_we) begin
        z_d = z_in;
      end
    end
  end

  // Architectural flags, forwarding register, redirect pulse and retire counter
  always_ff @(posedge clock) begin
    if (clear) begin
      c_flag      <= 1'b0;
      z_flag      <= 1'b0;
      fwd_valid   <= 1'b0;
      fwd_rd      <= '0;
      fwd_data    <= '0;
      pc_redirect <= 1'b0;
      pc_target   <= '0;
      retired     <= '0;
    end else if (enable) begin
      c_flag      <= c_d;
      z_flag      <= z_d;
      fwd_valid   <= rf_we;
      fwd_rd      <= Rd;
      fwd_data    <= rf_wd;
      pc_redirect <= rf_we & is_r7;
      pc_target   <= rf_wd;
      // Condition-failed slots still retire
      if (valid) retired <= retired + CNT_W'(1);
    end else begin
      // Stall: everything holds except the redirect pulse, which must not stretch
      pc_redirect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: each stimulus step pushes its hand-computed
// expectation; an independent monitor pops and compares at mid-cycle (comb outputs)
// and just after the edge (registered outputs).
module tb_wb_commit_unit;

  logic        clock = 1'b0;
  logic        clear, enable, valid, LW, LM, c_in, z_in, c_we, z_we;
  logic [4:0]  WB_Ct;
  logic [2:0]  Rd;
  logic [3:0]  opcode;
  logic [15:0] ALUout, Mem_DO, PC_plus, ZP9;
  logic        rf_we, c_flag, z_flag, fwd_valid, pc_redirect;
  logic [2:0]  rf_wa, fwd_rd;
  logic [15:0] rf_wd, fwd_data, pc_target, retired;

  typedef struct packed {
    logic [7:0]  id;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        c;
    logic        z;
    logic        fv;
    logic [2:0]  frd;
    logic [15:0] fd;
    logic        rdir;
    logic [15:0] tgt;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic busy    = 1'b0;
  logic [7:0] step_id = 8'd0;

  wb_commit_unit #(
    .DW(16),
    .RW(3),
    .CNT_W(16)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .enable      (enable),
    .valid       (valid),
    .WB_Ct       (WB_Ct),
    .Rd          (Rd),
    .opcode      (opcode),
    .LW          (LW),
    .LM          (LM),
    .ALUout      (ALUout),
    .Mem_DO      (Mem_DO),
    .PC_plus     (PC_plus),
    .ZP9         (ZP9),
    .c_in        (c_in),
    .z_in        (z_in),
    .c_we        (c_we),
    .z_we        (z_we),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] id, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL step %0d %s: got %h expected %h", id, name, act, exp);
  endtask

  // Monitor: comb outputs mid-cycle, registered outputs right after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        busy = 1'b1;
        chk("rf_we", e.id, 16'(rf_we), 16'(e.we));
        chk("rf_wa", e.id, 16'(rf_wa), 16'(e.wa));
        chk("rf_wd", e.id, rf_wd, e.wd);
        @(posedge clock);
        #2;
        chk("c_flag", e.id, 16'(c_flag), 16'(e.c));
        chk("z_flag", e.id, 16'(z_flag), 16'(e.z));
        chk("fwd_valid", e.id, 16'(fwd_valid), 16'(e.fv));
        chk("fwd_rd", e.id, 16'(fwd_rd), 16'(e.frd));
        chk("fwd_data", e.id, fwd_data, e.fd);
        chk("pc_redirect", e.id, 16'(pc_redirect), 16'(e.rdir));
        chk("pc_target", e.id, pc_target, e.tgt);
        chk("retired", e.id, retired, e.ret);
        busy = 1'b0;
      end
    end
  end

  // Apply one cycle of inputs; optionally push the expected response
  task automatic go(input logic push, input logic clr, en, vld, input logic [4:0] ct,
                    input logic [2:0] rd, input logic lw, lm,
                    input logic [15:0] alu, mem, pcp, zp9,
                    input logic cin, cwe, zin, zwe,
                    input logic we, input logic [15:0] wd, input logic c, z, fv,
                    input logic [2:0] frd, input logic [15:0] fd, input logic rdir,
                    input logic [15:0] tgt, ret);
    exp_t e;
    clear = clr; enable = en; valid = vld; WB_Ct = ct; Rd = rd; LW = lw; LM = lm;
    ALUout = alu; Mem_DO = mem; PC_plus = pcp; ZP9 = zp9;
    c_in = cin; c_we = cwe; z_in = zin; z_we = zwe;
    if (push) begin
      step_id++;
      e.id = step_id; e.we = we; e.wa = rd; e.wd = wd; e.c = c; e.z = z; e.fv = fv;
      e.frd = frd; e.fd = fd; e.rdir = rdir; e.tgt = tgt; e.ret = ret;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int guard;
    clear = 1'b1; enable = 1'b0; valid = 1'b0; WB_Ct = '0; Rd = '0; opcode = 4'h0;
    LW = 1'b0; LM = 1'b0; ALUout = '0; Mem_DO = '0; PC_plus = '0; ZP9 = '0;
    c_in = 1'b0; z_in = 1'b0; c_we = 1'b0; z_we = 1'b0;
    @(posedge clock);
    #1;
    //  p  clr en vld ct        rd lw lm alu      mem      pcp      zp9      cin cwe zin zwe
    //     we wd       c  z  fv frd fd       rdir tgt      ret
    go(1, 1, 1, 0, 5'b00100, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
       0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    // Build some state, then clear mid-stream (first clear cycle with enable low)
    go(1, 0, 1, 1, 5'b00100, 3, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0,
       1, 16'h1234, 1, 0, 1, 3, 16'h1234, 0, 16'h1234, 16'h0001);
    go(1, 0, 1, 1, 5'b00100, 4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1,
       1, 16'h0000, 1, 1, 1, 4, 16'h0000, 0, 16'h0000, 16'h0002);
    go(1, 1, 0, 0, 5'b00100, 5, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
       0, 16'h5555, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    go(1, 1, 1, 0, 5'b00100, 5, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
       0, 16'h5555, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    // Conditional on C with C=0: no write, no flag change, still retires
    go(1, 0, 1, 1, 5'b00110, 1, 0, 0, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 1,
       0, 16'hABCD, 0, 0, 0, 1, 16'hABCD, 0, 16'hABCD, 16'h0001);
    // ADD sets C
    go(1, 0, 1, 1, 5'b00100, 3, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0,
       1, 16'h1234, 1, 0, 1, 3, 16'h1234, 0, 16'h1234, 16'h0002);
    // Back-to-back: conditional on C sees the C just set
    go(1, 0, 1, 1, 5'b00110, 6, 0, 0, 16'h0BEE, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0,
       1, 16'h0BEE, 0, 0, 1, 6, 16'h0BEE, 0, 16'h0BEE, 16'h0003);
    // LW of zero: Z from loaded word, overriding z_in
    go(1, 0, 1, 1, 5'b01100, 2, 1, 0, 16'h7777, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1,
       1, 16'h0000, 0, 1, 1, 2, 16'h0000, 0, 16'h0000, 16'h0004);
    // Conditional on Z sees the LW result
    go(1, 0, 1, 1, 5'b00101, 5, 0, 0, 16'h00AA, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
       1, 16'h00AA, 0, 1, 1, 5, 16'h00AA, 0, 16'h00AA, 16'h0005);
    // Clear Z, then LM with Mem_DO=0, z_we=1, c_we=1 must leave flags alone
    go(1, 0, 1, 1, 5'b00100, 4, 0, 0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1,
       1, 16'h0001, 0, 0, 1, 4, 16'h0001, 0, 16'h0001, 16'h0006);
    go(1, 0, 1, 1, 5'b01100, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 1,
       1, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0007);
    // Conditional on Z with Z=0 fails
    go(1, 0, 1, 1, 5'b00101, 3, 0, 0, 16'h9999, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
       0, 16'h9999, 0, 0, 0, 3, 16'h9999, 0, 16'h9999, 16'h0008);
    // Write R7 from PC_plus: one-cycle redirect
    go(1, 0, 1, 1, 5'b10100, 7, 0, 0, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 0, 0, 0, 0,
       1, 16'h0040, 0, 0, 1, 7, 16'h0040, 1, 16'h0040, 16'h0009);
    // Bubble (ZP9 select, cond 11): pulse drops, no count
    go(1, 0, 1, 0, 5'b11011, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h01FF, 0, 0, 0, 0,
       0, 16'h01FF, 0, 0, 0, 0, 16'h01FF, 0, 16'h01FF, 16'h0009);
    // R7 write followed by a stall: pulse cleared on the stalled edge
    go(1, 0, 1, 1, 5'b10100, 7, 0, 0, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 0, 0, 0, 0,
       1, 16'h0080, 0, 0, 1, 7, 16'h0080, 1, 16'h0080, 16'h000A);
    for (int i = 0; i < 3; i++)
      go(1, 0, 0, 1, 5'b00100, 2, 0, 0, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 1,
         0, 16'h1111, 0, 0, 1, 7, 16'h0080, 0, 16'h0080, 16'h000A);
    // Unchecked live no-write slots to bring the counter to FFFF
    for (int i = 0; i < 65525; i++)
      go(0, 0, 1, 1, 5'b00000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    // Stall three cycles with a live slot: frozen at FFFF
    for (int i = 0; i < 3; i++)
      go(1, 0, 0, 1, 5'b00100, 3, 0, 0, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0,
         0, 16'h2222, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF);
    // Commit: counter wraps to 0000
    go(1, 0, 1, 1, 5'b00100, 3, 0, 0, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0,
       1, 16'h2222, 1, 0, 1, 3, 16'h2222, 0, 16'h2222, 16'h0000);
    go(0, 0, 1, 0, 5'b00000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0,
       0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    if (guard >= 20) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
